// File: rtl/hazard_pkg.sv
// Shared types and helpers for the MIPS32 pipeline hazard unit.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_E    = 2'd1,
        FWD_M    = 2'd2,
        FWD_W    = 2'd3
    } fwd_sel_e;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        MDU_WAIT = 2'd2
    } hz_state_e;

    localparam int REG_ZERO    = 0;
    localparam int STALL_CNT_W = 32;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (&v) ? v : v + STALL_CNT_W'(1);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline <-> hazard unit signal bundle: stage status in, stall/flush/forwarding out.
interface pipeline_hazard_ctrl_if #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2
);
    logic [NUM_SRC*REG_AW-1:0] src_d;
    logic [NUM_SRC-1:0]        src_used_d;
    logic                      mdu_op_d;
    logic                      mdu_use_d;
    logic                      reg_write_e;
    logic                      reg_write_m;
    logic                      reg_write_w;
    logic [REG_AW-1:0]         write_reg_e;
    logic [REG_AW-1:0]         write_reg_m;
    logic [REG_AW-1:0]         write_reg_w;
    logic                      mem_to_reg_e;
    logic                      mem_to_reg_m;
    logic [DATA_W-1:0]         alu_out_e;
    logic [DATA_W-1:0]         alu_out_m;
    logic [DATA_W-1:0]         result_w;
    logic                      mdu_start_e;
    logic                      redirect_e;
    logic [NUM_SRC-1:0]        fwd_en;
    logic [NUM_SRC*DATA_W-1:0] fwd_data;
    logic                      stall_f;
    logic                      stall_d;
    logic                      flush_d;
    logic                      flush_e;
    logic                      mdu_busy;
    logic [31:0]               stall_cnt;

    modport master (
        output src_d, src_used_d, mdu_op_d, mdu_use_d,
               reg_write_e, reg_write_m, reg_write_w,
               write_reg_e, write_reg_m, write_reg_w,
               mem_to_reg_e, mem_to_reg_m,
               alu_out_e, alu_out_m, result_w,
               mdu_start_e, redirect_e,
        input  fwd_en, fwd_data, stall_f, stall_d, flush_d, flush_e,
               mdu_busy, stall_cnt
    );

    modport slave (
        input  src_d, src_used_d, mdu_op_d, mdu_use_d,
               reg_write_e, reg_write_m, reg_write_w,
               write_reg_e, write_reg_m, write_reg_w,
               mem_to_reg_e, mem_to_reg_m,
               alu_out_e, alu_out_m, result_w,
               mdu_start_e, redirect_e,
        output fwd_en, fwd_data, stall_f, stall_d, flush_d, flush_e,
               mdu_busy, stall_cnt
    );
endinterface

// File: rtl/hazard_fwd_slot.sv
// One decode source operand: finds the youngest in-flight writer of the register
// and either selects it for forwarding or flags a load-use hazard.
module hazard_fwd_slot
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
)(
    input  logic              used,
    input  logic [REG_AW-1:0] src,
    input  logic              reg_write_e,
    input  logic              reg_write_m,
    input  logic              reg_write_w,
    input  logic [REG_AW-1:0] write_reg_e,
    input  logic [REG_AW-1:0] write_reg_m,
    input  logic [REG_AW-1:0] write_reg_w,
    input  logic              mem_to_reg_e,
    input  logic              mem_to_reg_m,
    output fwd_sel_e          fwd_sel,
    output logic              ld_haz
);
    logic live;
    logic hit_e;
    logic hit_m;
    logic hit_w;

    // $0 is hard-wired to zero, so a write to it must never be forwarded.
    assign live  = used && (src != REG_AW'(REG_ZERO));
    assign hit_e = live && reg_write_e && (write_reg_e == src);
    assign hit_m = live && reg_write_m && (write_reg_m == src);
    assign hit_w = live && reg_write_w && (write_reg_w == src);

    // The youngest matching stage decides; a load there means the value is not ready yet.
    always_comb begin
        fwd_sel = FWD_NONE;
        ld_haz  = 1'b0;
        if (hit_e) begin
            if (mem_to_reg_e) ld_haz  = 1'b1;
            else              fwd_sel = FWD_E;
        end else if (hit_m) begin
            if (mem_to_reg_m) ld_haz  = 1'b1;
            else              fwd_sel = FWD_M;
        end else if (hit_w) begin
            fwd_sel = FWD_W;
        end
    end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard unit for the 5-stage MIPS32 pipeline: operand forwarding, load-use and
// MDU stalls, redirect flush, and a saturating stall-cycle counter.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2,
    parameter int MDU_LAT = 4
)(
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave hz
);
    localparam int CNT_W = $clog2(MDU_LAT);

    logic [NUM_SRC-1:0]     slot_ld_haz;
    logic [CNT_W-1:0]       mdu_cnt_reg;
    logic [CNT_W-1:0]       mdu_cnt_next;
    hz_state_e              state_reg;
    hz_state_e              state_next;
    logic [STALL_CNT_W-1:0] stall_cnt_reg;

    logic ld_haz;
    logic mdu_busy;
    logic mdu_haz;
    logic stall_req;
    logic redirect;
    logic stall_hold;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_slot
            fwd_sel_e          sel;
            logic              ld;
            logic              en;
            logic [DATA_W-1:0] data;

            hazard_fwd_slot #(
                .REG_AW (REG_AW)
            ) u_slot (
                .used         (hz.src_used_d[gi]),
                .src          (hz.src_d[gi*REG_AW +: REG_AW]),
                .reg_write_e  (hz.reg_write_e),
                .reg_write_m  (hz.reg_write_m),
                .reg_write_w  (hz.reg_write_w),
                .write_reg_e  (hz.write_reg_e),
                .write_reg_m  (hz.write_reg_m),
                .write_reg_w  (hz.write_reg_w),
                .mem_to_reg_e (hz.mem_to_reg_e),
                .mem_to_reg_m (hz.mem_to_reg_m),
                .fwd_sel      (sel),
                .ld_haz       (ld)
            );

            always_comb begin
                data = '0;
                unique case (sel)
                    FWD_E:   data = hz.alu_out_e;
                    FWD_M:   data = hz.alu_out_m;
                    FWD_W:   data = hz.result_w;
                    default: data = '0;
                endcase
            end

            assign en                                = rst && (sel != FWD_NONE);
            assign hz.fwd_en[gi]                     = en;
            assign hz.fwd_data[gi*DATA_W +: DATA_W]  = en ? data : '0;
            assign slot_ld_haz[gi]                   = ld;
        end
    endgenerate

    assign ld_haz   = |slot_ld_haz;
    assign mdu_busy = (mdu_cnt_reg != '0);
    // The issuing cycle already counts as busy for a dependent D-stage instruction.
    assign mdu_haz  = (mdu_busy || hz.mdu_start_e) && (hz.mdu_op_d || hz.mdu_use_d);

    assign stall_req  = rst && (ld_haz || mdu_haz);
    assign redirect   = rst && hz.redirect_e;
    assign stall_hold = stall_req && !redirect;

    assign hz.stall_f   = stall_hold;
    assign hz.stall_d   = stall_hold;
    assign hz.flush_d   = redirect;
    assign hz.flush_e   = stall_req || redirect;
    assign hz.mdu_busy  = mdu_busy;
    assign hz.stall_cnt = stall_cnt_reg;

    // Redirects do not touch the counter: the in-flight mult/div is older than the branch.
    always_comb begin
        mdu_cnt_next = mdu_cnt_reg;
        if (hz.mdu_start_e)  mdu_cnt_next = CNT_W'(MDU_LAT - 1);
        else if (mdu_busy)   mdu_cnt_next = mdu_cnt_reg - CNT_W'(1);
    end

    // Stall-reason tracker, kept for debug probing.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            RUN: begin
                if (ld_haz)       state_next = LD_STALL;
                else if (mdu_haz) state_next = MDU_WAIT;
            end
            LD_STALL: if (!ld_haz)   state_next = RUN;
            MDU_WAIT: if (!mdu_busy) state_next = RUN;
            default:                 state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mdu_cnt_reg   <= '0;
            state_reg     <= RUN;
            stall_cnt_reg <= '0;
        end else begin
            mdu_cnt_reg <= mdu_cnt_next;
            state_reg   <= state_next;
            if (stall_hold) stall_cnt_reg <= sat_inc(stall_cnt_reg);
        end
    end
endmodule
